dp_job_scheduler: RTL and testbench

Shares the single 5-step arithmetic datapath between two requesters.
- Arbitrates round-robin, grants one job at a time.
- Sequences the datapath through its 16-bit control words, S1..S5, PASSES times per job.
- Reports completion with a done pulse tagged by the requester ID.
- Sits between the host-side request logic and the datapath, in the place of a free-running start-driven controller.

---
 rtl/dp_job_scheduler_pkg.sv | 39 +++
 rtl/dp_job_scheduler_if.sv | 29 ++
 rtl/dp_job_scheduler_arb.sv | 26 ++
 rtl/dp_job_scheduler.sv | 127 ++++++++++++
 tb/tb_dp_job_scheduler.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/dp_job_scheduler_pkg.sv
// Shared types and constants for the dual-requester datapath job scheduler.
// Contents: state enum (StIdle, StS1..StS5), the six datapath control words,
// the requester ID width, and the state-to-control-word decode.
package dp_sched_pkg;

   localparam int unsigned IdW = 1;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StS1   = 3'd1,
      StS2   = 3'd2,
      StS3   = 3'd3,
      StS4   = 3'd4,
      StS5   = 3'd5
   } state_e;

   localparam logic [15:0] CW_IDLE = 16'hE000;
   localparam logic [15:0] CW_S1   = 16'h1C08;
   localparam logic [15:0] CW_S2   = 16'h1B10;
   localparam logic [15:0] CW_S3   = 16'h1F9D;
   localparam logic [15:0] CW_S4   = 16'h0343;
   localparam logic [15:0] CW_S5   = 16'h0020;

   // Illegal encodings decode to CW_S5; the FSM recovers to StIdle on the next edge.
   function automatic logic [15:0] cw_decode(input state_e s);
      logic [15:0] cw;
      case (s)
         StIdle:  cw = CW_IDLE;
         StS1:    cw = CW_S1;
         StS2:    cw = CW_S2;
         StS3:    cw = CW_S3;
         StS4:    cw = CW_S4;
         StS5:    cw = CW_S5;
         default: cw = CW_S5;
      endcase
      return cw;
   endfunction

endpackage

// File: rtl/dp_job_scheduler_if.sv
// Host/datapath-facing bundle of the job scheduler.
//   req     : per-requester level request (host -> scheduler)
//   gnt     : one-hot one-cycle grant pulse
//   sel     : current job owner ID (datapath operand mux select)
//   busy    : job in progress
//   done    : one-cycle completion pulse, qualified by done_id
//   control : 16-bit datapath control word
// master = scheduler side, slave = host/datapath side.
interface dp_job_scheduler_if;

   logic [1:0]  req;
   logic [1:0]  gnt;
   logic        sel;
   logic        busy;
   logic        done;
   logic        done_id;
   logic [15:0] control;

   modport master (
      input  req,
      output gnt, sel, busy, done, done_id, control
   );

   modport slave (
      output req,
      input  gnt, sel, busy, done, done_id, control
   );

endinterface

// File: rtl/dp_job_scheduler_arb.sv
// rr_arb2: combinational 2-input round-robin arbiter.
//   req_i     : request vector
//   last_id_i : ID granted most recently
//   valid_o   : at least one request present
//   winner_o  : granted ID (on a tie, the one that did not win last)
module rr_arb2
   import dp_sched_pkg::*;
(
   input  logic [1:0]     req_i,
   input  logic [IdW-1:0] last_id_i,
   output logic           valid_o,
   output logic [IdW-1:0] winner_o
);

   always_comb begin
      valid_o  = |req_i;
      winner_o = '0;
      case (req_i)
         2'b01:   winner_o = 1'b0;
         2'b10:   winner_o = 1'b1;
         2'b11:   winner_o = ~last_id_i;
         default: winner_o = '0;
      endcase
   end

endmodule

// File: rtl/dp_job_scheduler.sv
// dp_job_scheduler: shares one 5-step datapath between two requesters.
// Grants jobs round-robin, sweeps the datapath S1..S5 PASSES times per job and
// reports completion with a done pulse tagged by the owner ID.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : dp_job_scheduler_if.master (req in; gnt/sel/busy/done/done_id/control out)
// Build option: DP_SCHED_CTRL_REG_EN registers control and delays busy/done/done_id
// by one cycle to keep them aligned with it; gnt/sel/arbitration timing unchanged.
module dp_job_scheduler
   import dp_sched_pkg::*;
#(
   parameter int unsigned PASSES = 1,
   parameter int unsigned NREQ   = 2
) (
   input logic                 clk,
   input logic                 rst,
   dp_job_scheduler_if.master  bus
);

   localparam logic [3:0] PassLast = 4'(PASSES - 1);

   state_e           state_q;
   logic [IdW-1:0]   last_id_q;
   logic [IdW-1:0]   sel_q;
   logic [NREQ-1:0]  gnt_q;
   logic             busy_q;
   logic             done_q;
   logic [IdW-1:0]   done_id_q;
   logic [3:0]       pass_cnt_q;

   logic [NREQ-1:0]  req_w;
   logic             arb_valid;
   logic [IdW-1:0]   arb_winner;

   assign req_w = bus.req;

   rr_arb2 u_arb (
      .req_i     (req_w),
      .last_id_i (last_id_q),
      .valid_o   (arb_valid),
      .winner_o  (arb_winner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         last_id_q  <= 1'b1;  // req[0] wins the first tie
         sel_q      <= '0;
         gnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         done_id_q  <= '0;
         pass_cnt_q <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (arb_valid) begin
                  state_q           <= StS1;
                  sel_q             <= arb_winner;
                  last_id_q         <= arb_winner;
                  gnt_q[arb_winner] <= 1'b1;
                  busy_q            <= 1'b1;
               end
            end
            StS1: state_q <= StS2;
            StS2: state_q <= StS3;
            StS3: state_q <= StS4;
            StS4: state_q <= StS5;
            StS5: begin
               if (pass_cnt_q < PassLast) begin
                  state_q    <= StS1;
                  pass_cnt_q <= pass_cnt_q + 4'd1;
               end else begin
                  state_q    <= StIdle;
                  pass_cnt_q <= '0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  done_id_q  <= sel_q;
               end
            end
            default: begin
               state_q    <= StIdle;
               pass_cnt_q <= '0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt = gnt_q;
   assign bus.sel = sel_q;

`ifdef DP_SCHED_CTRL_REG_EN
   logic [15:0]    control_q;
   logic           busy_dly_q;
   logic           done_dly_q;
   logic [IdW-1:0] done_id_dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         control_q     <= CW_IDLE;
         busy_dly_q    <= 1'b0;
         done_dly_q    <= 1'b0;
         done_id_dly_q <= '0;
      end else begin
         control_q     <= cw_decode(state_q);
         busy_dly_q    <= busy_q;
         done_dly_q    <= done_q;
         done_id_dly_q <= done_id_q;
      end
   end

   assign bus.control = control_q;
   assign bus.busy    = busy_dly_q;
   assign bus.done    = done_dly_q;
   assign bus.done_id = done_id_dly_q;
`else
   assign bus.control = cw_decode(state_q);
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
`endif

endmodule

// File: tb/tb_dp_job_scheduler.sv
// Directed bench for dp_job_scheduler: one instance with PASSES=1 and one with
// PASSES=3 share clock and reset. Expected values come from a cycle-indexed
// job timeline computed here, shifted by one cycle when DP_SCHED_CTRL_REG_EN is set.
module tb_dp_job_scheduler;

`ifdef DP_SCHED_CTRL_REG_EN
   localparam int R = 1;
`else
   localparam int R = 0;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [15:0] cw_tab [0:4];

   dp_job_scheduler_if if1 ();
   dp_job_scheduler_if if3 ();

   dp_job_scheduler #(.PASSES(1), .NREQ(2)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.master)
   );

   dp_job_scheduler #(.PASSES(3), .NREQ(2)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (if3.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic job_id(input logic first_id, input bit alt, input int j);
      return alt ? (first_id ^ logic'(j % 2)) : first_id;
   endfunction

   // Called one sample after the grant edge (c=0). Walks the job timeline cycle by cycle.
   task automatic run_job(input int which, input int jobs, input int passes,
                          input logic first_id, input bit alt, input int drop_at,
                          input string tag);
      int          len, per, ncyc, cu, j, p, jc;
      logic [15:0] e_ctl;
      logic        e_busy, e_done, e_id, e_sel;
      logic [1:0]  e_gnt;
      logic [15:0] o_ctl;
      logic        o_busy, o_done, o_id, o_sel;
      logic [1:0]  o_gnt;
      len  = 5 * passes;
      per  = len + 1;
      ncyc = jobs * per + 2;
      for (int c = 0; c < ncyc; c++) begin
         cu     = c - R;
         e_ctl  = 16'hE000;
         e_busy = 1'b0;
         e_done = 1'b0;
         e_id   = first_id;
         if (cu >= 0 && cu < jobs * per) begin
            j = cu / per;
            p = cu % per;
            if (p < len) begin
               e_busy = 1'b1;
               e_ctl  = cw_tab[p % 5];
            end else begin
               e_done = 1'b1;
               e_id   = job_id(first_id, alt, j);
            end
         end
         jc = c / per;
         if (jc > jobs - 1) jc = jobs - 1;
         e_sel = job_id(first_id, alt, jc);
         e_gnt = 2'b00;
         if ((c % per) == 0 && (c / per) < jobs)
            e_gnt = job_id(first_id, alt, c / per) ? 2'b10 : 2'b01;
         if (which == 1) begin
            o_ctl = if1.control; o_busy = if1.busy; o_done = if1.done;
            o_id  = if1.done_id; o_sel  = if1.sel;  o_gnt  = if1.gnt;
         end else begin
            o_ctl = if3.control; o_busy = if3.busy; o_done = if3.done;
            o_id  = if3.done_id; o_sel  = if3.sel;  o_gnt  = if3.gnt;
         end
         chk($sformatf("%s c%0d control", tag, c), 32'(o_ctl), 32'(e_ctl));
         chk($sformatf("%s c%0d busy", tag, c), 32'(o_busy), 32'(e_busy));
         chk($sformatf("%s c%0d done", tag, c), 32'(o_done), 32'(e_done));
         chk($sformatf("%s c%0d gnt", tag, c), 32'(o_gnt), 32'(e_gnt));
         chk($sformatf("%s c%0d sel", tag, c), 32'(o_sel), 32'(e_sel));
         if (e_done) chk($sformatf("%s c%0d done_id", tag, c), 32'(o_id), 32'(e_id));
         if (c == drop_at) begin
            if (which == 1) if1.req = 2'b00;
            else            if3.req = 2'b00;
         end
         step();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cw_tab[0] = 16'h1C08;
      cw_tab[1] = 16'h1B10;
      cw_tab[2] = 16'h1F9D;
      cw_tab[3] = 16'h0343;
      cw_tab[4] = 16'h0020;
      rst     = 1'b1;
      if1.req = 2'b00;
      if3.req = 2'b00;
      #1;
      // Reset values
      chk("rst control", 32'(if1.control), 32'hE000);
      chk("rst gnt", 32'(if1.gnt), 32'h0);
      chk("rst busy", 32'(if1.busy), 32'h0);
      chk("rst done", 32'(if1.done), 32'h0);
      chk("rst sel", 32'(if1.sel), 32'h0);
      chk("rst done_id", 32'(if1.done_id), 32'h0);
      chk("rst3 control", 32'(if3.control), 32'hE000);
      step();
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("idle no req busy", 32'(if1.busy), 32'h0);

      // Single job from requester 0 (first tie favours 0; single req wins anyway)
      if1.req = 2'b01;
      step();
      run_job(1, 1, 1, 1'b0, 1'b0, 0, "single");

      // Both requesting continuously: last_id=0, so 1 wins first, then alternate
      if1.req = 2'b11;
      step();
      run_job(1, 3, 1, 1'b1, 1'b1, 17, "rr");

      // PASSES=3 on the second instance, requester 1
      if3.req = 2'b10;
      step();
      run_job(3, 1, 3, 1'b1, 1'b0, 0, "passes3");

      // Reset in S3: outputs return to reset values without a clock edge
      if1.req = 2'b01;
      step();
      chk("rstmid gnt", 32'(if1.gnt), 32'h1);
      if1.req = 2'b00;
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid control", 32'(if1.control), 32'hE000);
      chk("rstmid busy", 32'(if1.busy), 32'h0);
      chk("rstmid done", 32'(if1.done), 32'h0);
      chk("rstmid sel", 32'(if1.sel), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("post-rst c%0d done", i), 32'(if1.done), 32'h0);
         chk($sformatf("post-rst c%0d busy", i), 32'(if1.busy), 32'h0);
      end

      // Owner drops req during S2: job completes, no further grant
      if1.req = 2'b01;
      step();
      run_job(1, 1, 1, 1'b0, 1'b0, 1, "drop");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
